// File: rtl/jkff_driver.sv
`default_nettype none
// jkff_driver: drives a JK flip-flop bank through LOAD/TOGGLE/CLEAR/PRESET, then verifies q/nq and retries.
// Rev 1.0
module jkff_driver #(
  parameter int N       = 4,
  parameter int RETRIES = 2
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         req,
  input  logic [1:0]   op,
  input  logic [N-1:0] data,
  input  logic [N-1:0] q,
  input  logic [N-1:0] nq,
  output logic [N-1:0] j,
  output logic [N-1:0] k,
  output logic         bank_prn,
  output logic         bank_clrn,
  output logic         ready,
  output logic         done,
  output logic         err,
  output logic [N-1:0] q_last
);

  localparam int            CW        = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
  localparam logic [CW-1:0] MAX_RETRY = CW'(RETRIES);

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_TOGGLE = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_PRESET = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRIVE = 2'b01,
    CHECK = 2'b10
  } state_t;

  state_t        state, state_d;
  logic [N-1:0]  target, target_d;
  logic [CW-1:0] retry_cnt, retry_d;
  logic [N-1:0]  j_d, k_d, q_last_d;
  logic          prn_d, clrn_d, done_d, err_d;
  logic [N-1:0]  req_target;
  logic          check_pass;

  // Expected bank value for the incoming request; TOGGLE uses q at the accept edge.
  always_comb begin
    req_target = data;
    case (op)
      OP_LOAD:   req_target = data;
      OP_TOGGLE: req_target = q ^ data;
      OP_CLEAR:  req_target = '0;
      default:   req_target = '1;
    endcase
  end

  // A contradictory nq (e.g. preset and clear both active) fails even if q matches.
  assign check_pass = (q == target) && (nq == ~q);
  assign ready      = (state == IDLE);

  always_comb begin
    state_d  = state;
    target_d = target;
    retry_d  = retry_cnt;
    j_d      = '0;
    k_d      = '0;
    prn_d    = 1'b1;
    clrn_d   = 1'b1;
    done_d   = 1'b0;
    err_d    = 1'b0;
    q_last_d = q_last;

    case (state)
      IDLE: begin
        if (req) begin
          state_d  = DRIVE;
          target_d = req_target;
          retry_d  = '0;
          case (op)
            OP_LOAD: begin
              j_d = data & ~q;
              k_d = ~data & q;
            end
            OP_TOGGLE: begin
              j_d = data;
              k_d = data;
            end
            OP_CLEAR:  clrn_d = 1'b0;
            OP_PRESET: prn_d  = 1'b0;
            default:   prn_d  = 1'b0;
          endcase
        end
      end

      DRIVE: state_d = CHECK;

      CHECK: begin
        q_last_d = q;
        if (check_pass) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (retry_cnt < MAX_RETRY) begin
          // Retries only push the bits that are still wrong; correct bits hold.
          retry_d = retry_cnt + CW'(1);
          state_d = DRIVE;
          j_d     = target & ~q;
          k_d     = ~target & q;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= IDLE;
      target    <= '0;
      retry_cnt <= '0;
      j         <= '0;
      k         <= '0;
      bank_prn  <= 1'b1;
      bank_clrn <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      q_last    <= '0;
    end else begin
      state     <= state_d;
      target    <= target_d;
      retry_cnt <= retry_d;
      j         <= j_d;
      k         <= k_d;
      bank_prn  <= prn_d;
      bank_clrn <= clrn_d;
      done      <= done_d;
      err       <= err_d;
      q_last    <= q_last_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jkff_driver.sv
`default_nettype none
// tb_jkff_driver: bank model plus timeline reference model for jkff_driver; directed and random stimulus.
module tb_jkff_driver;

  localparam int N       = 4;
  localparam int RETRIES = 2;

  logic         clk  = 1'b0;
  logic         clrn = 1'b0;
  logic         req  = 1'b0;
  logic [1:0]   op   = 2'b00;
  logic [N-1:0] data = '0;
  logic [N-1:0] q, nq, j, k, q_last;
  logic         bank_prn, bank_clrn, ready, done, err;

  logic [N-1:0] bq      = '0;
  logic [N-1:0] stuck0  = '0;
  logic [N-1:0] stuck1  = '0;
  logic [N-1:0] set_val = '0;
  logic         set_en  = 1'b0;
  logic         nq_bad  = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  jkff_driver #(.N(N), .RETRIES(RETRIES)) dut (
    .clk(clk), .clrn(clrn), .req(req), .op(op), .data(data),
    .q(q), .nq(nq), .j(j), .k(k), .bank_prn(bank_prn), .bank_clrn(bank_clrn),
    .ready(ready), .done(done), .err(err), .q_last(q_last)
  );

  // JK bank with async active-low preset/clear and optional stuck-at bits.
  assign q  = bq;
  assign nq = nq_bad ? bq : ~bq;

  always @(posedge clk or negedge bank_clrn or negedge bank_prn) begin
    if (!bank_clrn)     bq <= stuck1;
    else if (!bank_prn) bq <= ~stuck0 | stuck1;
    else if (set_en)    bq <= (set_val & ~stuck0) | stuck1;
    else                bq <= (((j & ~bq) | (~k & bq)) & ~stuck0) | stuck1;
  end

  // Reference: on acceptance, the whole cycle-by-cycle output timeline is planned up front.
  typedef struct packed {
    logic [N-1:0] j;
    logic [N-1:0] k;
    logic         prn;
    logic         clrn;
    logic         ready;
    logic         done;
    logic         err;
    logic [N-1:0] q_last;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         exp_now;
  logic [N-1:0] q_m     = '0;
  logic [N-1:0] qlast_m = '0;

  function automatic exp_t idle_ent(input logic [N-1:0] ql);
    exp_t e;
    e.j = '0; e.k = '0; e.prn = 1'b1; e.clrn = 1'b1;
    e.ready = 1'b1; e.done = 1'b0; e.err = 1'b0; e.q_last = ql;
    return e;
  endfunction

  task automatic plan(input logic [1:0] o, input logic [N-1:0] d);
    logic [N-1:0] tgt, cur;
    exp_t         e;
    bit           ok, fin;
    cur = q_m;
    fin = 1'b0;
    case (o)
      2'b00:   tgt = d;
      2'b01:   tgt = cur ^ d;
      2'b10:   tgt = '0;
      default: tgt = '1;
    endcase
    for (int a = 0; a <= RETRIES && !fin; a++) begin
      e = idle_ent(qlast_m);
      e.ready = 1'b0;
      if (a == 0 && o == 2'b01) begin
        e.j = d; e.k = d;
      end else if (a == 0 && o == 2'b10) begin
        e.clrn = 1'b0;
      end else if (a == 0 && o == 2'b11) begin
        e.prn = 1'b0;
      end else begin
        e.j = tgt & ~cur;
        e.k = ~tgt & cur;
      end
      exp_q.push_back(e);
      if (!e.clrn)     cur = '0;
      else if (!e.prn) cur = '1;
      else             cur = (e.j & ~cur) | (~e.k & cur);
      cur = (cur & ~stuck0) | stuck1;
      e = idle_ent(qlast_m);
      e.ready = 1'b0;
      exp_q.push_back(e);
      qlast_m = cur;
      ok = (cur == tgt) && !nq_bad;
      if (ok || a == RETRIES) begin
        e = idle_ent(cur);
        e.done = ok;
        e.err  = !ok;
        exp_q.push_back(e);
        fin = 1'b1;
      end
    end
    q_m = cur;
  endtask

  always @(posedge clk) begin
    if (!clrn) begin
      exp_q.delete();
      qlast_m = '0;
      exp_now = idle_ent('0);
    end else begin
      if (set_en) q_m = (set_val & ~stuck0) | stuck1;
      if (exp_now.ready && req) begin
        plan(op, data);
        exp_now = exp_q.pop_front();
      end else if (exp_q.size() > 0) begin
        exp_now = exp_q.pop_front();
      end else begin
        exp_now = idle_ent(qlast_m);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("j",         32'(j),         32'(exp_now.j));
    chk("k",         32'(k),         32'(exp_now.k));
    chk("bank_prn",  32'(bank_prn),  32'(exp_now.prn));
    chk("bank_clrn", 32'(bank_clrn), 32'(exp_now.clrn));
    chk("ready",     32'(ready),     32'(exp_now.ready));
    chk("done",      32'(done),      32'(exp_now.done));
    chk("err",       32'(err),       32'(exp_now.err));
    chk("q_last",    32'(q_last),    32'(exp_now.q_last));
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("ready_timeout", 32'(ready), 32'd1);
  endtask

  task automatic issue(input logic [1:0] o, input logic [N-1:0] d);
    wait_ready();
    req = 1'b1; op = o; data = d;
    tick();
    req = 1'b0;
  endtask

  task automatic set_bank(input logic [N-1:0] v, input logic [N-1:0] s0,
                          input logic [N-1:0] s1, input logic bad);
    req = 1'b0;
    wait_ready();
    set_val = v; stuck0 = s0; stuck1 = s1; nq_bad = bad; set_en = 1'b1;
    tick();
    set_en = 1'b0;
  endtask

  initial begin
    // Reset held with a pending request: nothing may be accepted.
    clrn = 1'b0; req = 1'b1; op = 2'b00; data = 4'b1111;
    repeat (3) tick();
    chk("rst_j",         32'(j),         32'h0);
    chk("rst_k",         32'(k),         32'h0);
    chk("rst_prn",       32'(bank_prn),  32'h1);
    chk("rst_clrn",      32'(bank_clrn), 32'h1);
    chk("rst_ready",     32'(ready),     32'h1);
    chk("rst_done",      32'(done),      32'h0);
    chk("rst_err",       32'(err),       32'h0);
    chk("rst_q_last",    32'(q_last),    32'h0);
    req = 1'b0;
    clrn = 1'b1;
    tick();

    // LOAD 0011 over 0101.
    set_bank(4'b0101, '0, '0, 1'b0);
    issue(2'b00, 4'b0011);
    chk("load_j", 32'(j), 32'b0010);
    chk("load_k", 32'(k), 32'b0100);
    tick(); tick();
    chk("load_done",   32'(done),   32'h1);
    chk("load_q_last", 32'(q_last), 32'b0011);

    // TOGGLE 1001 over 0011.
    issue(2'b01, 4'b1001);
    chk("tog_j", 32'(j), 32'b1001);
    chk("tog_k", 32'(k), 32'b1001);
    tick(); tick();
    chk("tog_done",   32'(done),   32'h1);
    chk("tog_q_last", 32'(q_last), 32'b1010);

    // CLEAR, then PRESET accepted in the done cycle.
    issue(2'b10, 4'b0000);
    chk("clr_pulse", 32'(bank_clrn), 32'h0);
    tick();
    chk("clr_release", 32'(bank_clrn), 32'h1);
    tick();
    chk("clr_done",   32'(done),   32'h1);
    chk("clr_q_last", 32'(q_last), 32'h0);
    req = 1'b1; op = 2'b11;
    tick();
    req = 1'b0;
    chk("pre_pulse", 32'(bank_prn), 32'h0);
    tick(); tick();
    chk("pre_done",   32'(done),   32'h1);
    chk("pre_q_last", 32'(q_last), 32'b1111);

    // Requests while busy are dropped.
    issue(2'b00, 4'b1100);
    req = 1'b1; op = 2'b11; data = 4'b1111;
    tick(); tick();
    chk("busy_done",   32'(done),   32'h1);
    chk("busy_q_last", 32'(q_last), 32'b1100);
    req = 1'b0;
    tick();
    chk("busy_idle_j", 32'(j), 32'h0);

    // Bit 0 stuck at 0: three drive attempts, then err.
    set_bank(4'b0000, 4'b0001, '0, 1'b0);
    issue(2'b00, 4'b0001);
    chk("stuck_j0", 32'(j), 32'b0001);
    chk("stuck_k0", 32'(k), 32'b0000);
    for (int r = 1; r <= RETRIES; r++) begin
      tick();
      tick();
      chk("stuck_jr", 32'(j), 32'b0001);
    end
    tick(); tick();
    chk("stuck_err",    32'(err),    32'h1);
    chk("stuck_done",   32'(done),   32'h0);
    chk("stuck_q_last", 32'(q_last), 32'h0);

    // nq disagreeing with q fails even when q matches.
    set_bank(4'b0000, '0, '0, 1'b1);
    issue(2'b00, 4'b0000);
    repeat (6) tick();
    chk("nq_err", 32'(err), 32'h1);
    set_bank(4'b0110, '0, '0, 1'b0);

    // Reset during CLEAR's drive cycle releases the clear at once.
    issue(2'b10, 4'b0000);
    chk("mid_clr_low", 32'(bank_clrn), 32'h0);
    #2 clrn = 1'b0;
    #1;
    chk("mid_clr_rel", 32'(bank_clrn), 32'h1);
    chk("mid_ready",   32'(ready),     32'h1);
    tick();
    chk("mid_done", 32'(done), 32'h0);
    chk("mid_err",  32'(err),  32'h0);
    tick();
    clrn = 1'b1;
    tick();
    set_bank(4'b0101, '0, '0, 1'b0);

    // Randomized traffic with occasional stuck bits and nq faults.
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 0) begin
        logic [N-1:0] s0, s1;
        s0 = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
        s1 = ($urandom_range(0, 2) == 0) ? (N'($urandom) & ~s0) : '0;
        set_bank(N'($urandom), s0, s1, $urandom_range(0, 9) == 0);
      end
      req  = 1'($urandom_range(0, 1));
      op   = 2'($urandom);
      data = N'($urandom);
      tick();
    end
    req = 1'b0;
    wait_ready();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish required finish by 1000000");
    $fatal(1);
  end

endmodule
`default_nettype wire
